// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM pipeline stage: access size encodings,
// the stage state enum and a helper that maps the illegal size onto a word.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        MS_IDLE,
        MS_REQ,
        MS_WAIT,
        MS_DONE,
        MS_DRAIN
    } mem_state_e;

    // Size 3 has no meaning on the bus, so it is issued as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? SZ_WORD : sz;
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational data alignment for the MEM stage: misalignment detection
// and store replication for the request side, shift/extend for load data.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  req_addr_lo,
    input  logic [1:0]  req_size,
    input  logic [31:0] store_src,
    output logic        misaligned,
    output logic [31:0] store_data,
    input  logic [1:0]  rsp_addr_lo,
    input  logic [1:0]  rsp_size,
    input  logic        rsp_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        misaligned = 1'b0;
        store_data = store_src;
        case (req_size)
            SZ_BYTE: store_data = {4{store_src[7:0]}};
            SZ_HALF: begin
                misaligned = req_addr_lo[0];
                store_data = {2{store_src[15:0]}};
            end
            default: misaligned = |req_addr_lo;
        endcase
    end

    // The addressed byte lane is moved down to bit 0 before extension.
    always_comb begin
        shifted   = rdata >> {rsp_addr_lo, 3'b000};
        load_data = shifted;
        case (rsp_size)
            SZ_BYTE: load_data = {{24{~rsp_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{~rsp_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores on an SRAM-like data bus, holds the
// result in a registered output slot and stalls EX while a transaction is open.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [31:0]       ex_out,
    input  logic [31:0]       rtdata,
    input  logic [4:0]        reg_waddr_i,
    input  logic              regwrite_i,
    input  logic [31:0]       pc_i,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic [31:0]       data_rdata,
    input  logic              data_data_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       wb_data,
    output logic [4:0]        reg_waddr_o,
    output logic              regwrite_o,
    output logic [31:0]       pc_o,
    output logic              addr_err_load,
    output logic              addr_err_store,
    output logic [31:0]       badvaddr,
    output logic              busy
);

    mem_state_e  state;
    logic        load_unsigned;
    logic        misaligned;
    logic        mis_err;
    logic        accept;
    logic [31:0] store_data;
    logic [31:0] load_data;

    mem_align u_align (
        .req_addr_lo  (ex_out[1:0]),
        .req_size     (mem_size),
        .store_src    (rtdata),
        .misaligned   (misaligned),
        .store_data   (store_data),
        .rsp_addr_lo  (data_addr[1:0]),
        .rsp_size     (data_size),
        .rsp_unsigned (load_unsigned),
        .rdata        (data_rdata),
        .load_data    (load_data)
    );

    assign in_ready = ((state == MS_IDLE) || ((state == MS_DONE) && out_ready)) && !flush;
    assign accept   = in_valid && in_ready;
    assign mis_err  = mem_en && misaligned;
    assign busy     = (state == MS_REQ) || (state == MS_WAIT) || (state == MS_DRAIN);

    // A new instruction may replace a full slot in the same cycle it is consumed,
    // so IDLE and DONE share the accept path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= MS_IDLE;
            load_unsigned  <= 1'b0;
            data_req       <= 1'b0;
            data_wr        <= 1'b0;
            data_size      <= SZ_BYTE;
            data_addr      <= '0;
            data_wdata     <= '0;
            out_valid      <= 1'b0;
            wb_data        <= '0;
            reg_waddr_o    <= '0;
            regwrite_o     <= 1'b0;
            pc_o           <= '0;
            addr_err_load  <= 1'b0;
            addr_err_store <= 1'b0;
            badvaddr       <= '0;
        end else begin
            case (state)
                MS_IDLE, MS_DONE: begin
                    if (flush) begin
                        state     <= MS_IDLE;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        reg_waddr_o    <= reg_waddr_i;
                        pc_o           <= pc_i;
                        wb_data        <= ex_out;
                        regwrite_o     <= regwrite_i && !mis_err;
                        addr_err_load  <= mis_err && !mem_wr;
                        addr_err_store <= mis_err && mem_wr;
                        badvaddr       <= mis_err ? ex_out : '0;
                        if (mem_en && !misaligned) begin
                            state         <= MS_REQ;
                            out_valid     <= 1'b0;
                            data_req      <= 1'b1;
                            data_wr       <= mem_wr;
                            data_size     <= norm_size(mem_size);
                            data_addr     <= ex_out;
                            data_wdata    <= store_data;
                            load_unsigned <= mem_unsigned;
                        end else begin
                            state     <= MS_DONE;
                            out_valid <= 1'b1;
                        end
                    end else if ((state == MS_DONE) && out_ready) begin
                        state     <= MS_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                MS_REQ: begin
                    if (flush) begin
                        data_req <= 1'b0;
                        state    <= data_addr_ok ? MS_DRAIN : MS_IDLE;
                    end else if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state    <= MS_WAIT;
                    end
                end
                MS_WAIT: begin
                    if (flush) begin
                        state <= data_data_ok ? MS_IDLE : MS_DRAIN;
                    end else if (data_data_ok) begin
                        state     <= MS_DONE;
                        out_valid <= 1'b1;
                        if (!data_wr) begin
                            wb_data <= load_data;
                        end
                    end
                end
                MS_DRAIN: begin
                    if (data_data_ok) begin
                        state <= MS_IDLE;
                    end
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage, directly downstream of EX.
- Consumes the EX result (address/ALU value, store data, writeback info) and runs loads/stores on an SRAM-like data bus (req / addr_ok / data_ok).
- Aligns store data and byte-extends load data; flags load/store address errors.
- Holds the result in a registered output slot and stalls upstream while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data-bus address width; must be 32 in this core.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  EX holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  exception/ERET flush; kills the held or in-flight instruction
- mem_en  in  1  instruction is load/store
- mem_wr  in  1  1 = store, 0 = load
- mem_size  in  2  0 byte, 1 half, 2 word (3 illegal, treated as word)
- mem_unsigned  in  1  zero-extend load
- ex_out  in  32  EX result / effective address
- rtdata  in  32  store source
- reg_waddr_i  in  5  destination register
- regwrite_i  in  1  writeback enable
- pc_i  in  32  instruction PC
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size
- data_addr  out  32  bus address (unaligned low bits passed through)
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  request accepted
- data_rdata  in  32  read data
- data_data_ok  in  1  response valid
- out_valid  out  1  result slot full
- out_ready  in  1  WB/downstream consumes slot
- wb_data  out  32  load result or passed ex_out
- reg_waddr_o  out  5  latched
- regwrite_o  out  1  latched; forced 0 on address error
- pc_o  out  32  latched
- addr_err_load  out  1  AdEL
- addr_err_store  out  1  AdES
- badvaddr  out  32  faulting address
- busy  out  1  stage in REQ/WAIT/DRAIN (to hazard unit)

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0: out_valid, data_req, flags, wb_data, latched fields. in_ready=1.
- States:
  - IDLE: slot empty.
  - REQ: data_req asserted.
  - WAIT: awaiting data_ok.
  - DONE: slot full.
  - DRAIN: discarding a killed response.
- in_ready = (IDLE | (DONE & out_ready)) & ~flush.
- Accept = in_valid & in_ready.
- Misalignment:
  - half with addr[0]!=0 → misaligned.
  - word with addr[1:0]!=0 → misaligned.
  - byte never misaligned.
- On accept, from IDLE or DONE (back-to-back, no bubble):
  - mem_en & ~misaligned → REQ. Latch addr, size, wr, unsigned, wdata, wb fields.
  - otherwise → DONE next cycle. wb_data=ex_out.
  - misaligned → DONE with addr_err_load=~mem_wr, addr_err_store=mem_wr, badvaddr=ex_out, regwrite_o=0. No bus request ever issued.
- DONE & out_ready & ~accept → IDLE.
- REQ: data_req=1; address, size and wdata stable until addr_ok.
  - addr_ok → WAIT.
  - data_ok never arrives in the same cycle as addr_ok.
- WAIT: on data_ok → DONE.
  - Load: wb_data = data_rdata shifted right by 8*addr[1:0], then sign/zero-extended per size.
  - Store: wb_data = ex_out.
- Store data:
  - byte: {4{rtdata[7:0]}}
  - half: {2{rtdata[15:0]}}
  - word: rtdata
- Flush:
  - IDLE/DONE → IDLE; out_valid=0 next cycle.
  - REQ without addr_ok → IDLE, request withdrawn.
  - REQ with addr_ok same cycle → DRAIN.
  - WAIT → DRAIN, or IDLE if data_ok arrives in that same cycle.
  - DRAIN: in_ready=0. On data_ok → IDLE; response discarded and never written back.
  - flush has priority over accept.
- busy = REQ|WAIT|DRAIN.
- One outstanding transaction maximum.

Decomposition:
- Shared package (cpu_defs):
  - size encodings: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - mem-stage state enum.
  - output struct grouping wb fields, if the pipeline uses a struct for the MEM→WB boundary.
- Sub-module mem_align: purely combinational. Misalignment detect, store replication, load shift/extend. Unit-testable alone.

Test Plan:
- lw addr 0x1000, addr_ok cycle 1, data_ok cycle 3 with rdata 0xDEADBEEF → data_req high cycles 1 only, out_valid cycle 4, wb_data 0xDEADBEEF, in_ready 0 during REQ/WAIT.
- lb addr 0x1003, rdata 0x80FF_0000; then lbu same → wb_data 0xFFFFFF80 then 0x00000080.
- sh rtdata 0x1234ABCD addr 0x2002 → data_wdata 0xABCDABCD, data_size 1, data_wr 1.
- lw addr 0x1002 → no data_req, addr_err_load=1, badvaddr 0x1002, regwrite_o 0; sw 0x1001 → addr_err_store=1.
- lw, addr_ok accepted, flush next cycle, data_ok 2 cycles later → DRAIN, out_valid stays 0, in_ready 0 until data_ok, then 1.
- Back-to-back ALU ops with out_ready=1 → one result per cycle; rst low mid-WAIT → all outputs 0 immediately, state IDLE.
